// File: rtl/bi_stream_to_binary_if.sv
// Stream-in / result-out bundle for the bipolar stochastic bitstream counter.
// The slave modport is the counter's own view; the master is the environment driving it.
interface bi_stream_to_binary_if #(
    parameter int unsigned LOGLEN = 8
);
    logic                     in_valid;
    logic                     in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [LOGLEN+1:0] out_data;
    logic        [LOGLEN:0]   out_ones;
    logic                     overrun;

    modport master (
        output in_valid, in, out_ready,
        input  out_valid, out_data, out_ones, overrun
    );

    modport slave (
        input  in_valid, in, out_ready,
        output out_valid, out_data, out_ones, overrun
    );
endinterface

// File: rtl/bi_stream_to_binary.sv
// Counts 1s over windows of 2^LOGLEN accepted bipolar bits and emits 2*ones - N
// through a single-entry result register with a valid/ready handshake.
module bi_stream_to_binary #(
    parameter int unsigned LOGLEN = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  clr,
    bi_stream_to_binary_if.slave bus
);
    localparam logic [0:0]        ACCUM = 1'b0;
    localparam logic [0:0]        HOLD  = 1'b1;
    localparam logic [LOGLEN+1:0] NVAL  = {2'b01, {LOGLEN{1'b0}}};

    logic [0:0]        state;
    logic [LOGLEN-1:0] cnt;
    logic [LOGLEN:0]   ones;
    logic [LOGLEN:0]   fin;
    logic [LOGLEN:0]   res_ones;
    logic [LOGLEN+1:0] res_data;
    logic [LOGLEN+1:0] data_next;
    logic              ovr;
    logic              done;
    logic              xfer;

    always_comb begin
        fin       = ones + {{LOGLEN{1'b0}}, bus.in};
        // Modular subtraction at LOGLEN+2 bits yields the correct two's-complement value.
        data_next = {fin, 1'b0} - NVAL;
        done      = bus.in_valid & ~clr & (cnt == {LOGLEN{1'b1}});
        xfer      = (state == HOLD) & bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ACCUM;
            cnt      <= '0;
            ones     <= '0;
            res_ones <= '0;
            res_data <= '0;
            ovr      <= 1'b0;
        end else begin
            if (clr) begin
                cnt  <= '0;
                ones <= '0;
                ovr  <= 1'b0;
            end else if (bus.in_valid) begin
                cnt  <= cnt + LOGLEN'(1);
                ones <= done ? '0 : fin;
                if (done && (state == HOLD) && !bus.out_ready) begin
                    ovr <= 1'b1;
                end
            end

            // The result register ignores clr so a pending result survives a restart.
            if (done) begin
                res_ones <= fin;
                res_data <= data_next;
                state    <= HOLD;
            end else if (xfer) begin
                state <= ACCUM;
            end
        end
    end

    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = res_data;
    assign bus.out_ones  = res_ones;
    assign bus.overrun   = ovr;
endmodule

// File: tb/tb_bi_stream_to_binary.sv
// Bench for bi_stream_to_binary: directed vector table on an N=8 instance plus
// random streams on an N=256 instance checked against a queue-based window model.
module tb_bi_stream_to_binary;
    logic clk = 1'b0;
    logic rst_n;
    logic clr3;
    logic clr8;

    always #5 clk = ~clk;

    bi_stream_to_binary_if #(.LOGLEN(3)) bus3 ();
    bi_stream_to_binary_if #(.LOGLEN(8)) bus8 ();

    bi_stream_to_binary #(.LOGLEN(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr3),
        .bus   (bus3.slave)
    );

    bi_stream_to_binary #(.LOGLEN(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr8),
        .bus   (bus8.slave)
    );

    typedef struct {
        logic clr;
        logic iv;
        logic din;
        logic rdy;
        logic ev;
        int   eones;
        int   edata;
        logic eovr;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic c, input logic iv, input logic din, input logic rdy);
        clr3          = c;
        bus3.in_valid = iv;
        bus3.in       = din;
        bus3.out_ready = rdy;
    endtask

    function automatic void add(input logic c, input logic iv, input logic din, input logic rdy,
                                input logic ev, input int eones, input int edata,
                                input logic eovr);
        vec_t v;
        v.clr = c; v.iv = iv; v.din = din; v.rdy = rdy;
        v.ev = ev; v.eones = eones; v.edata = edata; v.eovr = eovr;
        vecs.push_back(v);
    endfunction

    // Big-instance model: accepted bits collected in a queue, summed when a window fills.
    bit q[$];
    int m_valid, m_ones, m_data, m_ovr, m_windows;

    initial begin
        int probs[4];
        probs = '{0, 64, 192, 256};

        // All-ones window, then two 10101010 windows with out_ready high.
        for (int k = 0; k < 7; k++) add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 8, 8, 0);
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 8; k++) add(0, 1, (k % 2) == 0, 1, k == 7, 4, 0, 0);
        // All-zero window with in_valid toggling; done coincides with a transfer.
        for (int k = 0; k < 15; k++) add(0, k % 2, (k % 2) == 0, 0, 1, 4, 0, 0);
        add(0, 1, 0, 1, 1, 0, -8, 0);
        // Result overwritten while unconsumed, twice; then clr drops overrun only.
        for (int k = 0; k < 7; k++) add(0, 1, 1, 0, 1, 0, -8, 0);
        add(0, 1, 1, 0, 1, 8, 8, 1);
        for (int k = 0; k < 7; k++) add(0, 1, k < 2, 0, 1, 8, 8, 1);
        add(0, 1, 0, 0, 1, 2, -4, 1);
        add(1, 1, 1, 0, 1, 2, -4, 0);
        add(0, 0, 0, 1, 0, 2, -4, 0);

        rst_n = 1'b0;
        drive3(0, 0, 0, 0);
        clr8 = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.in = 1'b0;
        bus8.out_ready = 1'b0;
        step();
        step();
        check("rst_valid3", bus3.out_valid, 0);
        check("rst_data3", int'($signed(bus3.out_data)), 0);
        check("rst_ones3", bus3.out_ones, 0);
        check("rst_ovr3", bus3.overrun, 0);
        check("rst_valid8", bus8.out_valid, 0);
        check("rst_ovr8", bus8.overrun, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive3(vecs[i].clr, vecs[i].iv, vecs[i].din, vecs[i].rdy);
            step();
            check($sformatf("vec%0d_valid", i), bus3.out_valid, vecs[i].ev);
            check($sformatf("vec%0d_ovr", i), bus3.overrun, vecs[i].eovr);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_ones", i), bus3.out_ones, vecs[i].eones);
                check($sformatf("vec%0d_data", i), int'($signed(bus3.out_data)), vecs[i].edata);
            end
        end

        // clr on the 8th accepted bit discards the window.
        for (int k = 0; k < 7; k++) begin
            drive3(0, 1, 1, 1);
            step();
        end
        drive3(1, 1, 1, 1);
        step();
        check("clr_last_valid", bus3.out_valid, 0);
        for (int k = 0; k < 7; k++) begin
            drive3(0, 1, k < 3, 1);
            step();
        end
        check("after_clr_early", bus3.out_valid, 0);
        drive3(0, 1, 0, 1);
        step();
        check("after_clr_valid", bus3.out_valid, 1);
        check("after_clr_ones", bus3.out_ones, 3);
        check("after_clr_data", int'($signed(bus3.out_data)), -2);

        // Reset mid-window: partial window discarded, outputs cleared.
        for (int k = 0; k < 5; k++) begin
            drive3(0, 1, 1, 1);
            step();
        end
        rst_n = 1'b0;
        step();
        check("midrst_valid", bus3.out_valid, 0);
        check("midrst_ones", bus3.out_ones, 0);
        check("midrst_data", int'($signed(bus3.out_data)), 0);
        check("midrst_ovr", bus3.overrun, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive3(0, 1, 1, 0);
            step();
        end
        check("postrst_early", bus3.out_valid, 0);
        drive3(0, 1, 1, 0);
        step();
        check("postrst_valid", bus3.out_valid, 1);
        check("postrst_ones", bus3.out_ones, 8);
        check("postrst_data", int'($signed(bus3.out_data)), 8);
        drive3(0, 0, 0, 1);

        // Random streams on the N=256 instance.
        m_valid = 0; m_ones = 0; m_data = 0; m_ovr = 0; m_windows = 0;
        q.delete();
        foreach (probs[p]) begin
            int target;
            int cycles;
            target = m_windows + 25;
            cycles = 0;
            while (m_windows < target && cycles < 12000) begin
                logic c, iv, din, rdy;
                bit   done;
                c   = ($urandom_range(0, 1999) == 0);
                iv  = ($urandom_range(0, 9) != 0);
                din = ($urandom_range(0, 255) < probs[p]);
                rdy = ($urandom_range(0, 3) != 0);
                clr8 = c;
                bus8.in_valid = iv;
                bus8.in = din;
                bus8.out_ready = rdy;

                done = 0;
                if (c) begin
                    q.delete();
                    m_ovr = 0;
                end else if (iv) begin
                    q.push_back(din);
                    if (q.size() == 256) begin
                        int s;
                        s = 0;
                        foreach (q[j]) s += int'(q[j]);
                        q.delete();
                        done = 1;
                        if (m_valid != 0 && !rdy) m_ovr = 1;
                        m_valid = 1;
                        m_ones = s;
                        m_data = 2 * s - 256;
                        m_windows++;
                    end
                end
                if (!done && m_valid != 0 && rdy) m_valid = 0;

                step();
                cycles++;
                check("rnd_valid", bus8.out_valid, m_valid);
                check("rnd_ovr", bus8.overrun, m_ovr);
                if (m_valid != 0) begin
                    check("rnd_ones", bus8.out_ones, m_ones);
                    check("rnd_data", int'($signed(bus8.out_data)), m_data);
                end
            end
            check($sformatf("rnd_windows_p%0d", probs[p]), int'(m_windows >= target), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
